// File: rtl/mem_access_unit.sv
// Memory/branch stage between execute and writeback: issues one data-memory access at a time,
// resolves branches at accept. Optional ack timeout is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int DW      = 32,
    parameter int AW      = 4,
    parameter int RW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] store_data,
    input  logic [AW-1:0] mem_addr_in,
    input  logic [RW-1:0] rd_in,
    input  logic          wr_en_in,
    input  logic          ld,
    input  logic          st,
    input  logic          beq,
    input  logic          bne,
    input  logic [AW-1:0] br_target,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          out_valid,
    output logic [DW-1:0] result,
    output logic [RW-1:0] rd_out,
    output logic          wr_reg,
    output logic          branch_taken,
    output logic [AW-1:0] branch_target,
    output logic          flush,
    output logic          err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEM  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          is_load_q, is_load_d;
    logic [RW-1:0] rd_hold_q, rd_hold_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] result_q, result_d;
    logic [RW-1:0] rd_out_q, rd_out_d;
    logic          wr_reg_q, wr_reg_d;
    logic          branch_taken_q, branch_taken_d;
    logic [AW-1:0] branch_target_q, branch_target_d;
    logic          flush_q, flush_d;
    logic          accept_s;
    logic          taken_s;
    logic          tmo_hit_s;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;
`else
    logic [7:0] unused_timeout_s;
    assign unused_timeout_s = 8'(TIMEOUT);
`endif

    // Handshake and branch resolution, both purely on the accept cycle.
    always_comb begin
        accept_s = in_valid & (state_q == IDLE);
        // alu_result carries the compare flag; beq is checked first when both are set
        if (beq) begin
            taken_s = (alu_result == DW'(1));
        end else if (bne) begin
            taken_s = (alu_result == DW'(1));
        end else begin
            taken_s = 1'b0;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Abandon when this un-acked MEM cycle would bring the count up to TIMEOUT.
    always_comb begin
        if (state_q == MEM) begin
            tmo_hit_s = (tmo_cnt_q == TMO_LAST);
        end else begin
            tmo_hit_s = 1'b0;
        end
    end
`else
    // No timeout hardware: MEM waits for ack forever.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Next-state and next-output logic for the IDLE/MEM controller.
    always_comb begin
        state_d         = state_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        is_load_d       = is_load_q;
        rd_hold_d       = rd_hold_q;
        out_valid_d     = 1'b0;
        result_d        = result_q;
        rd_out_d        = rd_out_q;
        wr_reg_d        = 1'b0;
        branch_taken_d  = 1'b0;
        flush_d         = 1'b0;
        branch_target_d = branch_target_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        tmo_cnt_d       = tmo_cnt_q;
        err_d           = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept_s && taken_s) begin
                    branch_taken_d  = 1'b1;
                    flush_d         = 1'b1;
                    branch_target_d = br_target;
                end else begin
                    branch_target_d = branch_target_q;
                end
                if (accept_s && (ld || st)) begin
                    state_d     = MEM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = st & ~ld;
                    mem_addr_d  = mem_addr_in;
                    mem_wdata_d = store_data;
                    is_load_d   = ld;
                    rd_hold_d   = rd_in;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    tmo_cnt_d   = 8'd0;
`endif
                end else if (accept_s) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_result;
                    rd_out_d    = rd_in;
                    wr_reg_d    = wr_en_in;
                end else begin
                    state_d = IDLE;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    result_d    = is_load_q ? mem_rdata : mem_wdata_q;
                    rd_out_d    = rd_hold_q;
                    wr_reg_d    = is_load_q;
                end else if (tmo_hit_s) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    out_valid_d = 1'b1;
                    result_d    = {DW{1'b0}};
                    rd_out_d    = rd_hold_q;
                    wr_reg_d    = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    err_d       = 1'b1;
`endif
                end else begin
                    state_d = MEM;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= {AW{1'b0}};
            mem_wdata_q     <= {DW{1'b0}};
            is_load_q       <= 1'b0;
            rd_hold_q       <= {RW{1'b0}};
            out_valid_q     <= 1'b0;
            result_q        <= {DW{1'b0}};
            rd_out_q        <= {RW{1'b0}};
            wr_reg_q        <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_target_q <= {AW{1'b0}};
            flush_q         <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q       <= 8'd0;
            err_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            is_load_q       <= is_load_d;
            rd_hold_q       <= rd_hold_d;
            out_valid_q     <= out_valid_d;
            result_q        <= result_d;
            rd_out_q        <= rd_out_d;
            wr_reg_q        <= wr_reg_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            flush_q         <= flush_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            tmo_cnt_q       <= tmo_cnt_d;
            err_q           <= err_d;
`endif
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign rd_out        = rd_out_q;
    assign wr_reg        = wr_reg_q;
    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign flush         = flush_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DW, 32: data/result width in bits.
REQ-002 Parameter AW, 4: data-memory and branch-target address width.
REQ-003 Parameter RW, 4: destination register index width.
REQ-004 Parameter TIMEOUT, 15: max cycles awaiting mem_ack; legal range 1..255.
REQ-005 One clock; reset is synchronous and active-high. Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  execute-stage bundle valid.
- in_ready  out  1  unit accepts bundle this cycle.
- alu_result  in  DW  ALU result or branch compare flag.
- store_data  in  DW  store write data.
- mem_addr_in  in  AW  load/store address.
- rd_in  in  RW  destination register.
- wr_en_in  in  1  instruction writes register.
- ld, st, beq, bne  in  1 each  opcode flags.
- br_target  in  AW  branch target.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion.
- out_valid  out  1  writeback bundle valid (one-cycle pulse).
- result  out  DW  writeback data.
- rd_out  out  RW  writeback register.
- wr_reg  out  1  register write enable.
- branch_taken  out  1  branch taken pulse.
- branch_target  out  AW  registered target.
- flush  out  1  flush younger stages.
- err  out  1  memory timeout pulse.

Function
REQ-006 FSM states IDLE and MEM; in_ready = 1 only in IDLE.
REQ-007 Accept = in_valid & in_ready.
REQ-008 Accepted non-memory op: next cycle out_valid=1, result=alu_result, rd_out=rd_in, wr_reg=wr_en_in; stays IDLE.
REQ-009 Accepted ld or st: go to MEM; next cycle mem_req=1, mem_addr=mem_addr_in, mem_we=st&~ld, mem_wdata=store_data.
REQ-010 ld and st both set: treated as load only; no memory write.
REQ-011 In MEM, mem_req and its address/data/we are held stable until the cycle mem_ack=1 is sampled.
REQ-012 Ack cycle: mem_req deasserts next cycle, FSM returns to IDLE, out_valid=1 next cycle.
REQ-013 Load completion: result=mem_rdata captured on ack; wr_reg=1.
REQ-014 Store completion: result=store_data; wr_reg=0.
REQ-015 mem_ack sampled in IDLE is ignored.
REQ-016 Branch is taken when beq or bne is set with alu_result==1. beq has priority when both are set.
REQ-017 Branch resolves on the accept cycle. Next cycle: branch_taken=1, flush=1, branch_target=br_target, each for exactly one cycle.
REQ-018 Not-taken branch: no flush; branch_target holds its previous value.
REQ-019 Branch flags with ld/st: the branch resolves at accept, independent of memory completion.
REQ-020 out_valid, branch_taken, flush and err are single-cycle pulses; no downstream backpressure.

Reset
REQ-021 While reset=1 at a clock edge, the following are zero next cycle: FSM=IDLE and all outputs except in_ready; in_ready=1.
REQ-022 Reset during MEM aborts the access: mem_req=0 next cycle; no out_valid and no err for the aborted op.
REQ-023 reset has priority over in_valid, mem_ack and timeout.

Configuration
REQ-024 Macro MEM_ACCESS_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entering MEM and increments each MEM cycle without ack. When the count reaches TIMEOUT, the access is abandoned: next cycle mem_req=0, IDLE, err=1, out_valid=1, wr_reg=0.
- Undefined: no counter; MEM waits indefinitely; err is tied to 0.

Verification
REQ-025 ADD: alu_result=0x0000_002A, rd_in=3, wr_en_in=1 -> out_valid next cycle, result=0x2A, rd_out=3, wr_reg=1.
REQ-026 Load with mem_addr_in=5, ack after 3 cycles with mem_rdata=0xDEAD_BEEF -> mem_req high 3 cycles, in_ready=0, result=0xDEADBEEF, wr_reg=1 the cycle after ack.
REQ-027 beq with alu_result=1, br_target=9 -> branch_taken=1, flush=1, branch_target=9 for exactly one cycle. Repeat with alu_result=0 -> no flush.
REQ-028 Store of 0x1234 to addr 2, reset asserted while waiting for ack -> mem_req=0 next cycle, in_ready=1, no out_valid.
REQ-029 TIMEOUT=4, MEM_ACCESS_TIMEOUT_EN defined, no ack -> err=1 and out_valid with wr_reg=0 after 4 MEM cycles. Without the macro -> mem_req stays high indefinitely.
